dmem_responder: RTL and testbench
=================================

# dmem_responder

Handshaked, byte-addressed data-memory responder serving the memory stage's load/store requests. It accepts one request at a time, commits stores immediately, and returns load data after a programmable latency. Byte, half and word accesses are supported, with sign or zero extension on loads and an error response for illegal accesses. It sits between the memory pipeline stage (initiator) and the writeback path, so the pipeline can stall on memory.

## Interface
- `ADDR_WIDTH`, 32: request address width (byte address).
- `DATA_WIDTH`, 32: data width; fixed at 32 for lane logic.
- `NUM_LOCS`, 64: number of 32-bit words in the array.
- `READ_LATENCY`, 2: load latency in cycles, from accept edge to `resp_valid`; legal 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE and with `rst` low.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  DATA_WIDTH  load result; 0 for stores and errors.
- `resp_err`  out  1  access was illegal; qualified by `resp_valid`.

## Operation
- Accept occurs on a rising edge where `req_valid && req_ready`. At most one request is outstanding; there is no response backpressure.
- FSM states:
  - IDLE → BUSY on an accepted load when `READ_LATENCY` > 1.
  - IDLE → RESP on an accepted store, or on a load when `READ_LATENCY` = 1.
  - BUSY counts down; BUSY → RESP when the counter reaches 1.
  - RESP → IDLE unconditionally.
- `req_ready` = (state == IDLE) && !`rst`.
- Illegal access: `req_size` = 11; half with `addr[0]` = 1; word with `addr[1:0]` ≠ 0; or word index `addr >> 2` ≥ `NUM_LOCS`. An illegal access performs no write. It still follows normal latency and returns `resp_err` = 1 with `resp_rdata` = 0.
- Stores are little-endian and commit on the accept edge:
  - byte writes `wdata[7:0]` into lane `addr[1:0]`;
  - half writes `wdata[15:0]` into lanes `addr[1]*2 +: 2`;
  - word writes all four lanes.
- Loads read the addressed word at the accept edge into a hold register. The selected lane is shifted down by `addr[1:0]*8`, then extended per `req_unsigned` (the latched copy). Size and unsigned flags are latched at accept.
- RAM contents are not reset; only control and output registers are.

## Timing
- Reset values: state IDLE, counter 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0. `req_ready` is 0 while `rst` = 1 and 1 in the first cycle after reset.
- Store: accept at edge N; `resp_valid` high in cycle N+1; `req_ready` high again in cycle N+2.
- Load: accept at edge N; `resp_valid` high in cycle N+`READ_LATENCY`; `req_ready` high again in the following cycle.
- Back-to-back throughput: one store per 2 cycles; one load per `READ_LATENCY`+1 cycles.
- `resp_rdata` and `resp_err` are valid only while `resp_valid` = 1 and are driven to 0 otherwise.
- Reset mid-operation: the pending response is dropped and no `resp_valid` is emitted. A store already committed at its accept edge remains in the RAM.
- `req_*` inputs are ignored whenever `req_ready` = 0.

## Structure
- Package `dmem_pkg` holds:
  - `size_e` (SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10);
  - `state_e` (IDLE, BUSY, RESP);
  - the shared width constant 32.
- One combinational sub-module, `dmem_lane_align`, computes:
  - store byte-enable mask and shifted write data from size and `addr[1:0]`;
  - load extraction and extension from the held word, size, offset and unsigned flag.
- The top level contains the FSM, latency counter, hold/flag registers, error check and word-array RAM.

## Test plan
- **Word store/load round-trip:** after reset, store word `0xDEADBEEF` to addr `0x10`, then load word from `0x10` → `resp_rdata` = `0xDEADBEEF`, `resp_err` = 0, response exactly `READ_LATENCY` cycles after accept.
- **Byte load extension:** with `0x80FF7F01` at word 0, load byte at addr 1 signed → `0x0000007F`; addr 2 signed → `0xFFFFFFFF`; addr 3 unsigned → `0x00000080`.
- **Partial stores:** half store `0xABCD` to addr 2 over `0x11223344` → word reads `0xABCD3344`; byte store `0x55` to addr 1 → word reads `0xABCD5544`.
- **Illegal accesses:** load word at `0x06` → `resp_err` = 1, `rdata` = 0; store to word index 64 (addr `0x100`) → `resp_err` = 1 and no location changes; `req_size` = 11 → `resp_err` = 1.
- **Handshake:** hold `req_valid` high continuously with 3 loads and `READ_LATENCY` = 3 → `req_ready` low during BUSY/RESP; accepts occur at cycles 0, 4, 8; exactly 3 `resp_valid` pulses.
- **Reset mid-load:** assert `rst` one cycle after accepting a load → no `resp_valid`; `req_ready` returns 1 the cycle after `rst` falls; an earlier store is still readable.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  // Reserved size or a lane offset that does not match the access width.
  function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   size_illegal = 1'b0;
      2'b01:   size_illegal = off[0];
      2'b10:   size_illegal = |off;
      default: size_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the memory stage and the responder
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - little-endian lane steering for stores and load extraction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e                       st_size,
  input  logic [1:0]                  st_off,
  input  logic [DMEM_DATA_WIDTH-1:0]  st_wdata,
  output logic [3:0]                  st_be,
  output logic [DMEM_DATA_WIDTH-1:0]  st_data,
  input  logic [DMEM_DATA_WIDTH-1:0]  ld_word,
  input  size_e                       ld_size,
  input  logic [1:0]                  ld_off,
  input  logic                        ld_unsigned,
  output logic [DMEM_DATA_WIDTH-1:0]  ld_data
);

  logic [DMEM_DATA_WIDTH-1:0] ld_shifted;

  // Write data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    st_be   = 4'b0000;
    st_data = '0;
    case (st_size)
      SIZE_BYTE: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SIZE_WORD: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted = ld_word >> {ld_off, 3'b000};
    ld_data    = '0;
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                       : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                       : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      SIZE_WORD: ld_data = ld_word;
      default:   ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable load latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int NUM_LOCS     = 64,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus
);

  localparam int         IDX_W    = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [NUM_LOCS];

  logic [DATA_WIDTH-1:0] hold_q;
  size_e                 size_q;
  logic [1:0]            off_q;
  logic                  uns_q;
  logic                  err_q;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  accept;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      ram_idx;
  logic                  out_of_range;
  logic                  illegal;
  size_e                 req_size_e;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_word;
  size_e                 ld_size;
  logic [1:0]            ld_off;
  logic                  ld_uns;
  logic [DATA_WIDTH-1:0] ld_data;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_size_e    = size_e'(bus.req_size);
  assign word_idx      = bus.req_addr[ADDR_WIDTH-1:2];
  assign ram_idx       = word_idx[IDX_W-1:0];
  assign out_of_range  = word_idx >= (ADDR_WIDTH-2)'(NUM_LOCS);
  assign illegal       = out_of_range || size_illegal(bus.req_size, bus.req_addr[1:0]);
  assign rd_word       = mem[ram_idx];

  // A single-cycle load responds straight from IDLE, before anything is latched.
  always_comb begin
    if (state_q == IDLE) begin
      ld_word = rd_word;
      ld_size = req_size_e;
      ld_off  = bus.req_addr[1:0];
      ld_uns  = bus.req_unsigned;
    end else begin
      ld_word = hold_q;
      ld_size = size_q;
      ld_off  = off_q;
      ld_uns  = uns_q;
    end
  end

  dmem_lane_align u_lane_align (
    .st_size     (req_size_e),
    .st_off      (bus.req_addr[1:0]),
    .st_wdata    (bus.req_wdata),
    .st_be       (st_be),
    .st_data     (st_data),
    .ld_word     (ld_word),
    .ld_size     (ld_size),
    .ld_off      (ld_off),
    .ld_unsigned (ld_uns),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      size_q <= SIZE_BYTE;
      off_q  <= 2'b00;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      hold_q <= rd_word;
      size_q <= req_size_e;
      off_q  <= bus.req_addr[1:0];
      uns_q  <= bus.req_unsigned;
      err_q  <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Response registers are loaded only on entry to RESP so they read 0 otherwise.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_write) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = illegal;
          end else if (READ_LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = illegal;
            resp_rdata_d = illegal ? '0 : ld_data;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          cnt_d        = 4'd0;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = err_q ? '0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_responder #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .NUM_LOCS     (64),
    .READ_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   pulses      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        check("spurious_resp", {31'h0, bus.resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
        check({e.tag, "_err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
        check({e.tag, "_latency"}, cyc, e.due);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input string tag,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit track);
    int guard = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    if (track) sb.push_back('{tag, exp_rdata, exp_err, cyc + (wr ? 1 : LAT) - 1});
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_drain"}, sb.size(), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int acc[3];
    int lows[3];
    int p0;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_err", {31'h0, bus.resp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);

    issue(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, "st_word", 32'h0, 0, 1);
    issue(0, 32'h10, 32'h0, 2'b10, 0, "ld_word", 32'hDEADBEEF, 0, 1);
    issue(1, 32'hFC, 32'h600DCAFE, 2'b10, 0, "st_last", 32'h0, 0, 1);
    issue(0, 32'hFC, 32'h0, 2'b10, 0, "ld_last", 32'h600DCAFE, 0, 1);
    drain("roundtrip");

    issue(1, 32'h0, 32'h80FF7F01, 2'b10, 0, "st_ext", 32'h0, 0, 1);
    issue(0, 32'h1, 32'h0, 2'b00, 0, "ld_b1_s", 32'h0000007F, 0, 1);
    issue(0, 32'h2, 32'h0, 2'b00, 0, "ld_b2_s", 32'hFFFFFFFF, 0, 1);
    issue(0, 32'h3, 32'h0, 2'b00, 1, "ld_b3_u", 32'h00000080, 0, 1);
    issue(0, 32'h2, 32'h0, 2'b01, 0, "ld_h2_s", 32'hFFFF80FF, 0, 1);
    issue(0, 32'h0, 32'h0, 2'b01, 1, "ld_h0_u", 32'h00007F01, 0, 1);
    drain("ext");

    issue(1, 32'h0, 32'h11223344, 2'b10, 0, "st_base", 32'h0, 0, 1);
    issue(1, 32'h2, 32'h1234ABCD, 2'b01, 0, "st_half", 32'h0, 0, 1);
    issue(0, 32'h0, 32'h0, 2'b10, 0, "ld_after_half", 32'hABCD3344, 0, 1);
    issue(1, 32'h1, 32'h0000AA55, 2'b00, 0, "st_byte", 32'h0, 0, 1);
    issue(0, 32'h0, 32'h0, 2'b10, 0, "ld_after_byte", 32'hABCD5544, 0, 1);
    drain("partial");

    issue(0, 32'h6, 32'h0, 2'b10, 0, "ld_misalign_w", 32'h0, 1, 1);
    issue(0, 32'h1, 32'h0, 2'b01, 0, "ld_misalign_h", 32'h0, 1, 1);
    issue(1, 32'h100, 32'hCAFEF00D, 2'b10, 0, "st_oob", 32'h0, 1, 1);
    issue(0, 32'h100, 32'h0, 2'b10, 0, "ld_oob", 32'h0, 1, 1);
    issue(0, 32'h0, 32'h0, 2'b11, 0, "ld_rsvd", 32'h0, 1, 1);
    issue(1, 32'h10, 32'h0, 2'b11, 0, "st_rsvd", 32'h0, 1, 1);
    issue(0, 32'h0, 32'h0, 2'b10, 0, "ld_w0_intact", 32'hABCD5544, 0, 1);
    issue(0, 32'h10, 32'h0, 2'b10, 0, "ld_w4_intact", 32'hDEADBEEF, 0, 1);
    drain("illegal");

    p0 = pulses;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lows[i] = 0;
      while (bus.req_ready !== 1'b1 && lows[i] < 50) begin
        lows[i]++;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      acc[i] = cyc;
      sb.push_back('{"hs_ld", 32'hDEADBEEF, 1'b0, cyc + LAT - 1});
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain("handshake");
    check("hs_accept_gap1", acc[1] - acc[0], 32'd4);
    check("hs_accept_gap2", acc[2] - acc[0], 32'd8);
    check("hs_ready_low1", lows[1], LAT);
    check("hs_ready_low2", lows[2], LAT);
    check("hs_pulses", pulses - p0, 32'd3);

    issue(1, 32'h20, 32'h12345678, 2'b10, 0, "st_pre_rst", 32'h0, 0, 1);
    drain("pre_rst");
    issue(0, 32'h20, 32'h0, 2'b10, 0, "ld_killed", 32'h0, 0, 0);
    p0 = pulses;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_ready", {31'h0, bus.req_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", {31'h0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    check("mid_rst_no_pulse", pulses - p0, 32'd0);
    issue(0, 32'h20, 32'h0, 2'b10, 0, "ld_post_rst", 32'h12345678, 0, 1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
